// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready pipeline stage: stage state encoding and
// the occupancy values reported alongside it.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(stage_state_e s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_FULL: return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// WIDTH-bit data register with synchronous reset, synchronous clear and load
// enable; reset and clear both force zero, otherwise load on enable.
module pipe_reg_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that fully registers the upstream ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    stage_state_e     state_q, state_d;
    logic [1:0]       occ_q;
    logic             in_fire, out_fire;
    logic             main_load, main_from_skid, skid_load;
    logic [WIDTH-1:0] skid_q, main_d;
    logic             data_rst, data_clr;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = occ_q;
    assign data_rst  = reset & CLEAR_DATA;
    assign data_clr  = flush & CLEAR_DATA;
    assign main_d    = main_from_skid ? skid_q : in_data;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire && SKID) begin
                    skid_load = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards any incoming payload; an outgoing one already completed.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_of(state_d);
        end
    end

    pipe_reg_en #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_i (data_rst),
        .clr_i (data_clr),
        .en_i  (main_load),
        .d_i   (main_d),
        .q_o   (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Ready comes from a flop so no path exists from out_ready to in_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = in_ready_q & ~reset;

            pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
                .clk   (clk),
                .rst_i (data_rst),
                .clr_i (data_clr),
                .en_i  (skid_load),
                .d_i   (in_data),
                .q_o   (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = (~out_valid | out_ready) & ~reset;
            assign skid_q   = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: three instances (skid+clear, no-skid,
// skid without data clear), scoreboard queues popped by per-instance monitors.
module tb_pipe_stage_skid;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: SKID=1, CLEAR_DATA=1
    logic         a_rst, a_fl, a_iv, a_ir, a_ov, a_or;
    logic [W-1:0] a_id, a_od;
    logic [1:0]   a_occ;
    // Instance B: SKID=0, CLEAR_DATA=1
    logic         b_rst, b_fl, b_iv, b_ir, b_ov, b_or;
    logic [W-1:0] b_id, b_od;
    logic [1:0]   b_occ;
    // Instance C: SKID=1, CLEAR_DATA=0
    logic         c_rst, c_fl, c_iv, c_ir, c_ov, c_or;
    logic [W-1:0] c_id, c_od;
    logic [1:0]   c_occ;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] q_c[$];

    pipe_stage_skid #(.WIDTH(W), .SKID(1'b1), .CLEAR_DATA(1'b1)) dut_a (
        .clk(clk), .reset(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ));

    pipe_stage_skid #(.WIDTH(W), .SKID(1'b0), .CLEAR_DATA(1'b1)) dut_b (
        .clk(clk), .reset(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ));

    pipe_stage_skid #(.WIDTH(W), .SKID(1'b1), .CLEAR_DATA(1'b0)) dut_c (
        .clk(clk), .reset(c_rst), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .occupancy(c_occ));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every output handshake must match the head of its scoreboard.
    always @(negedge clk) begin
        if (!a_rst && a_ov && a_or) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL A_unexpected: got %h want none", a_od);
            end else begin
                $display("A out %h", a_od);
                chk("A_out", 32'(a_od), 32'(q_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!b_rst && b_ov && b_or) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL B_unexpected: got %h want none", b_od);
            end else begin
                $display("B out %h", b_od);
                chk("B_out", 32'(b_od), 32'(q_b.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!c_rst && c_ov && c_or) begin
            if (q_c.size() == 0) begin
                total++; bad++;
                $display("FAIL C_unexpected: got %h want none", c_od);
            end else begin
                $display("C out %h", c_od);
                chk("C_out", 32'(c_od), 32'(q_c.pop_front()));
            end
        end
    end

    initial begin
        {a_rst, b_rst, c_rst} = 3'b111;
        {a_fl, a_iv, a_or, b_fl, b_iv, b_or, c_fl, c_iv, c_or} = '0;
        a_id = '0; b_id = '0; c_id = '0;

        // Reset held for two cycles
        @(negedge clk);
        chk("A_ir_in_reset", 32'(a_ir), 32'd0);
        cyc();
        @(negedge clk);
        chk("A_ir_in_reset2", 32'(a_ir), 32'd0);
        cyc();
        {a_rst, b_rst, c_rst} = 3'b000;
        @(negedge clk);
        chk("A_ir_after_reset", 32'(a_ir), 32'd1);
        chk("A_ov_after_reset", 32'(a_ov), 32'd0);
        chk("A_occ_after_reset", 32'(a_occ), 32'd0);
        chk("A_od_after_reset", 32'(a_od), 32'd0);

        // A: streaming 0x11..0x18 with out_ready held high
        a_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            a_iv = 1'b1;
            a_id = W'(16'h11 + i);
            q_a.push_back(W'(16'h11 + i));
            $display("A in  %h", a_id);
            @(negedge clk);
            chk("A_stream_ir", 32'(a_ir), 32'd1);
            if (i > 0) chk("A_stream_occ", 32'(a_occ), 32'd1);
        end
        cyc();
        a_iv = 1'b0;
        @(negedge clk);
        chk("A_stream_tail_occ", 32'(a_occ), 32'd1);
        cyc();
        @(negedge clk);
        chk("A_stream_drained_occ", 32'(a_occ), 32'd0);
        chk("A_stream_drained_ov", 32'(a_ov), 32'd0);

        // A: three-cycle downstream stall while sending A0, A1, A2
        cyc();
        a_or = 1'b0; a_iv = 1'b1; a_id = 16'h00A0; q_a.push_back(16'h00A0);
        @(negedge clk);
        chk("A_stall_ir0", 32'(a_ir), 32'd1);
        cyc();
        a_id = 16'h00A1; q_a.push_back(16'h00A1);
        @(negedge clk);
        chk("A_stall_ir1", 32'(a_ir), 32'd1);
        chk("A_stall_hold1", 32'(a_od), 32'h00A0);
        chk("A_stall_occ1", 32'(a_occ), 32'd1);
        cyc();
        a_id = 16'h00A2; q_a.push_back(16'h00A2);
        @(negedge clk);
        chk("A_stall_ir_full", 32'(a_ir), 32'd0);
        chk("A_stall_occ_full", 32'(a_occ), 32'd2);
        chk("A_stall_hold2", 32'(a_od), 32'h00A0);
        cyc();
        a_or = 1'b1;
        @(negedge clk);
        chk("A_release_ir_still0", 32'(a_ir), 32'd0);
        cyc();
        @(negedge clk);
        chk("A_release_ir_up", 32'(a_ir), 32'd1);
        cyc();
        a_iv = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("A_stall_drained_occ", 32'(a_occ), 32'd0);

        // A: flush in ONE discards a simultaneous in_fire
        cyc();
        a_or = 1'b0; a_iv = 1'b1; a_id = 16'h00D0;
        cyc();
        a_id = 16'hBEEF; a_fl = 1'b1;
        @(negedge clk);
        chk("A_flush_one_ir", 32'(a_ir), 32'd1);
        cyc();
        a_fl = 1'b0; a_iv = 1'b0;
        @(negedge clk);
        chk("A_flush_one_ov", 32'(a_ov), 32'd0);
        chk("A_flush_one_occ", 32'(a_occ), 32'd0);

        // A: flush when FULL
        cyc();
        a_iv = 1'b1; a_id = 16'h00C0;
        cyc();
        a_id = 16'h00C1;
        cyc();
        a_id = 16'hBEEF; a_fl = 1'b1;
        @(negedge clk);
        chk("A_full_occ", 32'(a_occ), 32'd2);
        cyc();
        a_fl = 1'b0; a_iv = 1'b0;
        @(negedge clk);
        chk("A_flush_full_ov", 32'(a_ov), 32'd0);
        chk("A_flush_full_occ", 32'(a_occ), 32'd0);
        chk("A_flush_full_od", 32'(a_od), 32'd0);
        chk("A_flush_full_ir", 32'(a_ir), 32'd1);
        a_or = 1'b1;
        repeat (3) cyc();

        // B: combinational ready and back-to-back 0x5, 0x6
        b_or = 1'b0; b_iv = 1'b1; b_id = 16'h0005; q_b.push_back(16'h0005);
        $display("B in  %h", b_id);
        @(negedge clk);
        chk("B_ir_empty", 32'(b_ir), 32'd1);
        cyc();
        b_id = 16'h0006;
        #1;
        chk("B_ir_follows_low", 32'(b_ir), 32'd0);
        b_or = 1'b1;
        #1;
        chk("B_ir_follows_high", 32'(b_ir), 32'd1);
        q_b.push_back(16'h0006);
        $display("B in  %h", b_id);
        cyc();
        b_iv = 1'b0;
        @(negedge clk);
        chk("B_occ_max1", 32'(b_occ), 32'd1);
        cyc();
        b_or = 1'b0;
        @(negedge clk);
        chk("B_drained_ov", 32'(b_ov), 32'd0);

        // B: reset while holding a stalled payload
        cyc();
        b_iv = 1'b1; b_id = 16'h0007;
        cyc();
        b_iv = 1'b0; b_rst = 1'b1;
        @(negedge clk);
        chk("B_ir_in_reset", 32'(b_ir), 32'd0);
        chk("B_ov_before_reset_edge", 32'(b_ov), 32'd1);
        cyc();
        @(negedge clk);
        chk("B_ir_in_reset2", 32'(b_ir), 32'd0);
        chk("B_ov_after_reset_edge", 32'(b_ov), 32'd0);
        chk("B_occ_after_reset_edge", 32'(b_occ), 32'd0);
        cyc();
        b_rst = 1'b0;
        @(negedge clk);
        chk("B_ir_after_release", 32'(b_ir), 32'd1);

        // C: flush without data clear keeps out_data
        cyc();
        c_or = 1'b0; c_iv = 1'b1; c_id = 16'h1234;
        @(negedge clk);
        chk("C_ir", 32'(c_ir), 32'd1);
        cyc();
        c_iv = 1'b0; c_fl = 1'b1;
        @(negedge clk);
        chk("C_held_ov", 32'(c_ov), 32'd1);
        chk("C_held_od", 32'(c_od), 32'h1234);
        cyc();
        c_fl = 1'b0;
        @(negedge clk);
        chk("C_flush_ov", 32'(c_ov), 32'd0);
        chk("C_flush_od", 32'(c_od), 32'h1234);
        chk("C_flush_occ", 32'(c_occ), 32'd0);
        c_or = 1'b1;
        repeat (2) cyc();

        chk("A_queue_empty", 32'(q_a.size()), 32'd0);
        chk("B_queue_empty", 32'(q_b.size()), 32'd0);
        chk("C_queue_empty", 32'(q_c.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
